alu: RTL and testbench

//  32-bit integer ALU for the single-cycle CPU datapath, registered at its output.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_if.sv | 32 +++
 rtl/alu_comb.sv | 51 +++++
 rtl/alu.sv | 43 ++++
 tb/tb_alu.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: operation-select width and the aluc encodings.
// The control unit imports these same names to drive aluc.
package alu_pkg;

  localparam int ALUC_W = 4;

  typedef logic [ALUC_W-1:0] aluc_t;

  localparam aluc_t ALU_ADD   = 4'd0;
  localparam aluc_t ALU_SUB   = 4'd1;
  localparam aluc_t ALU_AND   = 4'd2;
  localparam aluc_t ALU_OR    = 4'd3;
  localparam aluc_t ALU_XOR   = 4'd4;
  localparam aluc_t ALU_NOR   = 4'd5;
  localparam aluc_t ALU_LUI   = 4'd6;
  localparam aluc_t ALU_SLT   = 4'd7;
  localparam aluc_t ALU_SLTU  = 4'd8;
  localparam aluc_t ALU_SLL   = 4'd9;
  localparam aluc_t ALU_SRL   = 4'd10;
  localparam aluc_t ALU_RSVD  = 4'd11;
  localparam aluc_t ALU_SRA   = 4'd12;
  localparam aluc_t ALU_ROR   = 4'd13;
  localparam aluc_t ALU_PASSA = 4'd14;
  localparam aluc_t ALU_PASSB = 4'd15;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle. The master (datapath) drives operands and the
// operation select; the slave (the ALU) returns the registered result and
// zero flag.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  aluc_t                   aluc;
  logic        [WIDTH-1:0] r;
  logic                    z;

  modport master (
    output a,
    output b,
    output aluc,
    input  r,
    input  z
  );

  modport slave (
    input  a,
    input  b,
    input  aluc,
    output r,
    output z
  );

endinterface

// File: rtl/alu_comb.sv
// Pure combinational ALU datapath: res = f(a, b, aluc) plus a zero flag
// computed from that same combinational result.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  aluc_t                   aluc_i,
  output logic        [WIDTH-1:0] res_o,
  output logic                    res_zero_o
);

  // Shift/rotate amount always comes from the low five bits of operand A.
  logic [4:0]       shamt;
  logic [WIDTH-1:0] b_u;
  logic [WIDTH-1:0] ror_res;

  assign shamt = a_i[4:0];
  assign b_u   = $unsigned(b_i);

  // A left shift by WIDTH yields zero, so amount 0 degenerates to b itself.
  assign ror_res = (b_u >> shamt) | (b_u << (WIDTH - int'(shamt)));

  // Operation select; every aluc value has a defined, X-free result.
  always_comb begin
    res_o = '0;
    case (aluc_i)
      ALU_ADD:   res_o = $unsigned(a_i + b_i);
      ALU_SUB:   res_o = $unsigned(a_i - b_i);
      ALU_AND:   res_o = $unsigned(a_i & b_i);
      ALU_OR:    res_o = $unsigned(a_i | b_i);
      ALU_XOR:   res_o = $unsigned(a_i ^ b_i);
      ALU_NOR:   res_o = $unsigned(~(a_i | b_i));
      ALU_LUI:   res_o = {b_u[15:0], {(WIDTH-16){1'b0}}};
      ALU_SLT:   res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_SLTU:  res_o = {{(WIDTH-1){1'b0}}, ($unsigned(a_i) < b_u)};
      ALU_SLL:   res_o = b_u << shamt;
      ALU_SRL:   res_o = b_u >> shamt;
      ALU_SRA:   res_o = $unsigned(b_i >>> shamt);
      ALU_ROR:   res_o = ror_res;
      ALU_PASSA: res_o = $unsigned(a_i);
      ALU_PASSB: res_o = b_u;
      default:   res_o = '0;
    endcase
  end

  assign res_zero_o = (res_o == '0);

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU with a one-cycle registered output. The zero flag is
// registered alongside the result from the same combinational value, so it
// never lags r by a cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] r_d;
  logic             z_d;
  logic [WIDTH-1:0] r_q;
  logic             z_q;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a_i        (bus.a),
    .b_i        (bus.b),
    .aluc_i     (bus.aluc),
    .res_o      (r_d),
    .res_zero_o (z_d)
  );

  // Output register: async clear to r=0/z=1, otherwise load every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      z_q <= 1'b1;
    end else begin
      r_q <= r_d;
      z_q <= z_d;
    end
  end

  assign bus.r = r_q;
  assign bus.z = z_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  // Reference model built from the operation definitions using plain
  // arithmetic: shifts as multiply/divide by powers of two, rotate bit by bit.
  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int              sh;
    longint unsigned prod;
    longint          sb;
    longint          d;
    longint          q;
    logic [31:0]     t;
    sh = int'(a[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return b[15:0] * 32'd65536;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9: begin
        prod = {32'd0, b} * (64'd1 << sh);
        return prod[31:0];
      end
      4'd10: return b / (32'd1 << sh);
      4'd12: begin
        sb = longint'($signed(b));
        d  = longint'(1) << sh;
        q  = sb / d;
        if (sb < 0 && (sb % d) != 0) q = q - 1;
        return q[31:0];
      end
      4'd13: begin
        t = b;
        for (int i = 0; i < sh; i++) t = {t[0], t[31:1]};
        return t;
      end
      4'd14: return a;
      4'd15: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] er, input logic ez);
    tests++;
    if (bus.r !== er || bus.z !== ez) begin
      failed++;
      $display("FAIL %s: got r=%h z=%b, expected r=%h z=%b", nm, bus.r, bus.z, er, ez);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.a    = a;
    bus.b    = b;
    bus.aluc = op;
  endtask

  // Apply one operation, clock it in and compare against the model.
  task automatic run_model(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
    logic [31:0] er;
    er = model(a, b, op);
    drive(a, b, op);
    @(posedge clk);
    #1;
    check(nm, er, (er == 32'd0));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;

    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd0,  32'h01fe0100, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd1,  32'h000000fe, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd2,  32'h00ff0001, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd3,  32'h00ff00ff, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd4,  32'h000000fe, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd5,  32'hff00ff00, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd6,  32'h00010000, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd7,  32'h00000000, 1'b1});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd8,  32'h00000000, 1'b1});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd9,  32'h80000000, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd10, 32'h00000000, 1'b1});
    vecs.push_back('{32'h00ff00ff, 32'h00ff0001, 4'd12, 32'h00000000, 1'b1});
    vecs.push_back('{32'h00ff00ff, 32'h80000000, 4'd12, 32'hffffffff, 1'b0});
    vecs.push_back('{32'h00ff00ff, 32'h80000000, 4'd13, 32'h00000001, 1'b0});
    vecs.push_back('{32'h00ff0001, 32'h00ff0001, 4'd4,  32'h00000000, 1'b1});
    vecs.push_back('{32'h00ff0001, 32'h00ff0001, 4'd1,  32'h00000000, 1'b1});
    vecs.push_back('{32'hffffffff, 32'h00000001, 4'd7,  32'h00000001, 1'b0});
    vecs.push_back('{32'hffffffff, 32'h00000001, 4'd8,  32'h00000000, 1'b1});
    vecs.push_back('{32'hffffffff, 32'h00000001, 4'd0,  32'h00000000, 1'b1});
    vecs.push_back('{32'h00000000, 32'h12345678, 4'd13, 32'h12345678, 1'b0});
    vecs.push_back('{32'h00000020, 32'h12345678, 4'd9,  32'h12345678, 1'b0});
    vecs.push_back('{32'h00000004, 32'h12345678, 4'd13, 32'h81234567, 1'b0});
    vecs.push_back('{32'h12345678, 32'hdeadbeef, 4'd11, 32'h00000000, 1'b1});

    // Reset held across edges
    rst_n = 1'b0;
    drive(32'd3, 32'd4, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'd0, 1'b1);

    // Release: first edge loads current inputs
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_add", 32'd7, 1'b0);

    // Async assertion between edges clears at once
    drive(32'h00ff00ff, 32'h00ff0001, 4'd3);
    @(posedge clk);
    #1;
    check("pre_async", 32'h00ff00ff, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'd0, 1'b1);
    @(posedge clk);
    #1;
    check("async_hold", 32'd0, 1'b1);
    rst_n = 1'b1;
    drive(32'd3, 32'd4, 4'd0);
    @(posedge clk);
    #1;
    check("rerelease_add", 32'd7, 1'b0);

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].r, vecs[i].z);
    end

    // Back-to-back sweep of every aluc value
    ra = 32'h8765_4321;
    rb = 32'hf0f0_1234;
    for (int op = 0; op < 16; op++) begin
      drive(ra, rb, 4'(op));
      @(posedge clk);
      #1;
      if (op == 11)      check("sweep_rsvd", 32'd0, 1'b1);
      else if (op == 14) check("sweep_passa", ra, 1'b0);
      else if (op == 15) check("sweep_passb", rb, 1'b0);
      else               check($sformatf("sweep_op%0d", op), model(ra, rb, 4'(op)),
                               (model(ra, rb, 4'(op)) == 32'd0));
    end

    // Randomized operands and ops against the model
    for (int n = 0; n < 400; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 15));
      if (n % 7 == 0) rb = ra;
      if (n % 11 == 0) rb = {$urandom_range(0, 1) == 1, 31'($urandom)} | 32'h8000_0000;
      run_model($sformatf("rand%0d_op%0d", n, rop), ra, rb, rop);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
